// File: rtl/color_history_writer_if.sv
// color_history_writer_if: bundles the read-side history stream, the write port
//   and the status outputs of color_history_writer.
// Ports: none (signal bundle only); HIST_W sets the history word width.
// slave = the writer itself (consumes hist_*, drives write_*/status);
//   master = the side that feeds it (color_history read port, arbiter, control).
interface color_history_writer_if #(
  parameter int HIST_W = 4
) ();
  // read-side history stream
  logic              hist_valid;
  logic [HIST_W-1:0] hist_data;
  logic [9:0]        hist_x;
  logic [9:0]        hist_y;
  logic              pixel_hit;
  // control
  logic              clear_req;
  logic              write_grant;
  // write port
  logic [9:0]        write_x;
  logic [9:0]        write_y;
  logic [HIST_W-1:0] write_data;
  logic              write_en;
  // status
  logic              pixel_stable;
  logic              stable_valid;
  logic              clear_busy;
  logic              overflow;
  logic [15:0]       drop_count;

  modport slave (
    input  hist_valid, hist_data, hist_x, hist_y, pixel_hit, clear_req, write_grant,
    output write_x, write_y, write_data, write_en,
    output pixel_stable, stable_valid, clear_busy, overflow, drop_count
  );

  modport master (
    output hist_valid, hist_data, hist_x, hist_y, pixel_hit, clear_req, write_grant,
    input  write_x, write_y, write_data, write_en,
    input  pixel_stable, stable_valid, clear_busy, overflow, drop_count
  );
endinterface

// File: rtl/color_history_writer.sv
// color_history_writer: shifts the current-frame colour match into each pixel's
//   history word and writes it back; sweeps the whole memory to zero after reset/clear_req.
// Latency: hist_valid in cycle N -> pixel_stable/stable_valid in N+1, write_en with
//   that entry in N+2 (empty FIFO). Backpressure: write_grant low holds the current
//   write; updates queue in a FIFO_DEPTH-entry FIFO and are dropped (overflow pulse,
//   saturating drop_count) when it is full and not popping.
// Ports: clk_50, reset (synchronous, active-high); bus (slave modport) carries
//   hist_valid/hist_data/hist_x/hist_y/pixel_hit, clear_req, write_grant in and
//   write_x/write_y/write_data/write_en, pixel_stable/stable_valid, clear_busy,
//   overflow, drop_count out.
// Optional: define HIST_SKIP_SAME_EN to skip write-back of unchanged histories.
module color_history_writer #(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int HIST_W        = 4,
  parameter int FIFO_DEPTH    = 4,   // power of two, >= 2
  parameter int STABLE_THRESH = 3
) (
  input logic                   clk_50,
  input logic                   reset,
  color_history_writer_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [9:0] LAST_X = 10'(H_RES - 1);
  localparam logic [9:0] LAST_Y = 10'(V_RES - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  typedef struct packed {
    logic [9:0]        x;
    logic [9:0]        y;
    logic [HIST_W-1:0] hist;
  } entry_t;

  function automatic int popcount(input logic [HIST_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < HIST_W; i++) n = n + int'(v[i]);
    return n;
  endfunction

  // ---------------- state ----------------
  state_t            state_q, state_d;
  logic [9:0]        sweep_x_q, sweep_x_d;
  logic [9:0]        sweep_y_q, sweep_y_d;

  logic              stage_valid_q, stage_valid_d;
  logic [9:0]        stage_x_q, stage_x_d;
  logic [9:0]        stage_y_q, stage_y_d;
  logic [HIST_W-1:0] stage_hist_q, stage_hist_d;
  logic              pixel_stable_q, pixel_stable_d;
`ifdef HIST_SKIP_SAME_EN
  logic              stage_same_q, stage_same_d;
`endif

  entry_t            fifo_mem_q [FIFO_DEPTH];
  entry_t            fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;

  logic              overflow_q, overflow_d;
  logic [15:0]       drop_count_q, drop_count_d;

  // ---------------- update stage ----------------
  logic [HIST_W-1:0] new_hist;

  always_comb begin
    new_hist       = {bus.hist_data[HIST_W-2:0], bus.pixel_hit};
    stage_valid_d  = bus.hist_valid;
    stage_x_d      = stage_x_q;
    stage_y_d      = stage_y_q;
    stage_hist_d   = stage_hist_q;
    pixel_stable_d = pixel_stable_q;
`ifdef HIST_SKIP_SAME_EN
    stage_same_d   = stage_same_q;
`endif
    if (bus.hist_valid) begin
      stage_x_d      = bus.hist_x;
      stage_y_d      = bus.hist_y;
      stage_hist_d   = new_hist;
      pixel_stable_d = (popcount(new_hist) >= STABLE_THRESH);
`ifdef HIST_SKIP_SAME_EN
      stage_same_d   = (new_hist == bus.hist_data);
`endif
    end
  end

  // ---------------- write-back FIFO ----------------
  logic   fifo_empty, fifo_full;
  logic   push_req, push, pop, drop, flush;
  entry_t head;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    // Same slot index, different wrap bit: every slot occupied.
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    // Updates only enter the FIFO in S_RUN; during a clear they vanish quietly.
    push_req   = stage_valid_q && (state_q == S_RUN);
`ifdef HIST_SKIP_SAME_EN
    push_req   = push_req && !stage_same_q;
`endif
    pop        = (state_q == S_RUN) && !fifo_empty && bus.write_grant;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push       = push_req && (!fifo_full || pop);
    drop       = push_req && fifo_full && !pop;
    flush      = (state_q == S_RUN) && bus.clear_req;

    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = '{x: stage_x_q, y: stage_y_q, hist: stage_hist_q};

    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    overflow_d   = drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d   = state_q;
    sweep_x_d = sweep_x_q;
    sweep_y_d = sweep_y_q;
    case (state_q)
      S_CLEAR: begin
        if (bus.clear_req) begin
          sweep_x_d = '0;
          sweep_y_d = '0;
        end else if (bus.write_grant) begin
          if (sweep_x_q == LAST_X) begin
            sweep_x_d = '0;
            if (sweep_y_q == LAST_Y) begin
              // Leave the address at (0,0) ready for the next clear.
              sweep_y_d = '0;
              state_d   = S_RUN;
            end else begin
              sweep_y_d = sweep_y_q + 10'd1;
            end
          end else begin
            sweep_x_d = sweep_x_q + 10'd1;
          end
        end
      end
      S_RUN: begin
        if (bus.clear_req) begin
          state_d   = S_CLEAR;
          sweep_x_d = '0;
          sweep_y_d = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q        <= S_CLEAR;
      sweep_x_q      <= '0;
      sweep_y_q      <= '0;
      stage_valid_q  <= 1'b0;
      stage_x_q      <= '0;
      stage_y_q      <= '0;
      stage_hist_q   <= '0;
      pixel_stable_q <= 1'b0;
`ifdef HIST_SKIP_SAME_EN
      stage_same_q   <= 1'b0;
`endif
      fifo_mem_q     <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      overflow_q     <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      sweep_x_q      <= sweep_x_d;
      sweep_y_q      <= sweep_y_d;
      stage_valid_q  <= stage_valid_d;
      stage_x_q      <= stage_x_d;
      stage_y_q      <= stage_y_d;
      stage_hist_q   <= stage_hist_d;
      pixel_stable_q <= pixel_stable_d;
`ifdef HIST_SKIP_SAME_EN
      stage_same_q   <= stage_same_d;
`endif
      fifo_mem_q     <= fifo_mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      overflow_q     <= overflow_d;
      drop_count_q   <= drop_count_d;
    end
  end

  // ---------------- FSM: outputs ----------------
  logic              write_en_c, clear_busy_c;
  logic [9:0]        write_x_c, write_y_c;
  logic [HIST_W-1:0] write_data_c;

  always_comb begin
    write_en_c   = 1'b0;
    write_x_c    = '0;
    write_y_c    = '0;
    write_data_c = '0;
    clear_busy_c = 1'b0;
    // Outputs stay quiet while reset is asserted.
    if (!reset) begin
      case (state_q)
        S_CLEAR: begin
          write_en_c   = 1'b1;
          write_x_c    = sweep_x_q;
          write_y_c    = sweep_y_q;
          clear_busy_c = 1'b1;
        end
        S_RUN: begin
          write_en_c   = !fifo_empty;
          write_x_c    = head.x;
          write_y_c    = head.y;
          write_data_c = head.hist;
        end
        default: ;
      endcase
    end
  end

  assign bus.write_en     = write_en_c;
  assign bus.write_x      = write_x_c;
  assign bus.write_y      = write_y_c;
  assign bus.write_data   = write_data_c;
  assign bus.clear_busy   = clear_busy_c;
  assign bus.pixel_stable = pixel_stable_q;
  assign bus.stable_valid = stage_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.drop_count   = drop_count_q;

endmodule

// File: tb/tb_color_history_writer.sv
// Testbench for color_history_writer with a reduced 8x4 frame so clear sweeps stay short.
module tb_color_history_writer;
  localparam int HR = 8;
  localparam int VR = 4;

  logic clk_50 = 1'b0;
  logic reset  = 1'b1;
  logic exp_we;

  color_history_writer_if #(.HIST_W(4)) bus ();

  color_history_writer #(
    .H_RES(HR), .V_RES(VR), .HIST_W(4), .FIFO_DEPTH(4), .STABLE_THRESH(3)
  ) dut (
    .clk_50(clk_50),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_50 = ~clk_50;

  int n_chk   = 0;
  int n_pass  = 0;
  int ov_seen = 0;
  logic [23:0] wq[$];   // expected granted writes {x, y, data}
  logic        sq[$];   // expected pixel_stable per stable_valid

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  function automatic int pc(input logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n = n + int'(v[i]);
    return n;
  endfunction

  // Drive one update for the current cycle and record what it must produce.
  task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [3:0] d,
                      input logic hit, input bit wr);
    logic [3:0] nh;
    bit do_wr;
    nh    = {d[2:0], hit};
    do_wr = wr;
`ifdef HIST_SKIP_SAME_EN
    if (nh == d) do_wr = 1'b0;
`endif
    bus.hist_valid = 1'b1;
    bus.hist_x     = x;
    bus.hist_y     = y;
    bus.hist_data  = d;
    bus.pixel_hit  = hit;
    sq.push_back(pc(nh) >= 3);
    if (do_wr) wq.push_back({x, y, nh});
  endtask

  task automatic idle();
    bus.hist_valid = 1'b0;
  endtask

  // Monitor: compares every granted write and every stable_valid against the queues.
  always @(negedge clk_50) begin
    if (bus.overflow === 1'b1) ov_seen++;
    if (bus.write_en === 1'b1 && bus.write_grant === 1'b1) begin
      if (wq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got (%0d,%0d,%b), expected no write",
                 bus.write_x, bus.write_y, bus.write_data);
      end else begin
        chk("write_xyd", 32'({bus.write_x, bus.write_y, bus.write_data}), 32'(wq.pop_front()));
      end
    end
    if (bus.stable_valid === 1'b1) begin
      if (sq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_stable: got stable_valid=1, expected 0");
      end else begin
        chk("pixel_stable", 32'(bus.pixel_stable), 32'(sq.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000ns");
    $fatal(1);
  end

  initial begin
    bit done;
    bus.hist_valid  = 1'b0;
    bus.hist_data   = '0;
    bus.hist_x      = '0;
    bus.hist_y      = '0;
    bus.pixel_hit   = 1'b0;
    bus.clear_req   = 1'b0;
    bus.write_grant = 1'b0;
    reset           = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_write_en",     32'(bus.write_en),     0);
    chk("rst_stable_valid", 32'(bus.stable_valid), 0);
    chk("rst_pixel_stable", 32'(bus.pixel_stable), 0);
    chk("rst_overflow",     32'(bus.overflow),     0);
    chk("rst_drop_count",   32'(bus.drop_count),   0);
    chk("rst_write_xyd",    32'({bus.write_x, bus.write_y, bus.write_data}), 0);

    // Clear sweep with grant held high: raster order, data 0
    for (int y = 0; y < VR; y++)
      for (int x = 0; x < HR; x++) wq.push_back({10'(x), 10'(y), 4'b0});
    bus.write_grant = 1'b1;
    reset = 1'b0;
    #1;
    chk("sweep_busy_first", 32'(bus.clear_busy), 1);
    repeat (HR * VR - 1) tick();
    chk("sweep_busy_last", 32'(bus.clear_busy), 1);
    tick();
    chk("sweep_busy_fall", 32'(bus.clear_busy), 0);
    chk("sweep_we_off",    32'(bus.write_en),   0);
    chk("sweep_all_done",  32'(wq.size()),      0);

    // Basic update: 0101 + hit -> 1011, popcount 3
    send(10'd10, 10'd20, 4'b0101, 1'b1, 1'b1);
    tick(); idle();
    chk("lat_n1_we", 32'(bus.write_en), 0);
    tick();
    chk("lat_n2_we",   32'(bus.write_en), 1);
    chk("lat_n2_xyd",  32'({bus.write_x, bus.write_y, bus.write_data}),
                       32'({10'd10, 10'd20, 4'b1011}));
    tick();
    chk("lat_n3_we", 32'(bus.write_en), 0);

    // Unchanged history 1111 + hit
    send(10'd5, 10'd6, 4'b1111, 1'b1, 1'b1);
    tick(); idle(); tick();
`ifdef HIST_SKIP_SAME_EN
    exp_we = 1'b0;
`else
    exp_we = 1'b1;
`endif
    chk("same_hist_we", 32'(bus.write_en), 32'(exp_we));
    repeat (2) tick();

    // Overflow: six updates with grant low, first four kept
    bus.write_grant = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(10'(30 + 12 * i), 10'(40 + 12 * i), 4'(i + 1), 1'b1, i < 4);
      tick();
    end
    idle();
    repeat (3) tick();
    chk("ovf_pulses",     32'(ov_seen),        2);
    chk("ovf_drop_count", 32'(bus.drop_count), 2);
    chk("ovf_hold_we",    32'(bus.write_en),   1);
    chk("ovf_head_x",     32'(bus.write_x),    30);

    // Push while full together with the first pop: accepted, not dropped
    send(10'd7, 10'd8, 4'b0010, 1'b0, 1'b1);
    tick(); idle();
    bus.write_grant = 1'b1;
    repeat (8) tick();
    chk("fullpp_drop_count", 32'(bus.drop_count), 2);
    chk("fullpp_pulses",     32'(ov_seen),        2);
    chk("drain_done",        32'(wq.size()),      0);

    // Clear mid-run with three entries queued
    bus.write_grant = 1'b0;
    send(10'd100, 10'd101, 4'b0011, 1'b1, 1'b0); tick();
    send(10'd102, 10'd103, 4'b0011, 1'b1, 1'b0); tick();
    send(10'd104, 10'd105, 4'b0011, 1'b1, 1'b0); tick();
    idle();
    repeat (2) tick();
    chk("pre_clear_we", 32'(bus.write_en), 1);
    chk("pre_clear_x",  32'(bus.write_x),  100);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    chk("clr_busy", 32'(bus.clear_busy), 1);
    chk("clr_we",   32'(bus.write_en),   1);
    chk("clr_xyd",  32'({bus.write_x, bus.write_y, bus.write_data}), 0);

    // Updates during the clear: no writes, no drops
    send(10'd200, 10'd201, 4'b0001, 1'b1, 1'b0); tick();
    send(10'd202, 10'd203, 4'b1000, 1'b0, 1'b0); tick();
    idle();
    repeat (2) tick();
    chk("clr_drop_count", 32'(bus.drop_count), 2);

    // Sweep with grant toggling every cycle: each address exactly once
    for (int y = 0; y < VR; y++)
      for (int x = 0; x < HR; x++) wq.push_back({10'(x), 10'(y), 4'b0});
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      bus.write_grant = ~bus.write_grant;
      tick();
      if (bus.clear_busy == 1'b0) done = 1'b1;
    end
    chk("toggle_sweep_done", 32'(bus.clear_busy), 0);
    bus.write_grant = 1'b1;
    repeat (6) tick();
    chk("toggle_sweep_all", 32'(wq.size()),      0);
    chk("stable_all_seen",  32'(sq.size()),      0);
    chk("final_pulses",     32'(ov_seen),        2);
    chk("final_drop_count", 32'(bus.drop_count), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/color_history_writer.md
Name: color_history_writer

Overview:
- Write-side companion of color_history: consumes each history word returned by the read port (read_data, data_valid, just_read_x, just_read_y) together with the current-frame colour-match bit.
- Shifts the match bit into the 4-frame history and writes the updated word back through color_history's write port (write_x, write_y, write_data, write_en).
- Contains a small write-back FIFO, a memory-clear sweeper FSM, and a registered "stable pixel" decision for the VGA overlay.

Parameters:
- H_RES, 640, pixels per line; clear sweep x range 0..H_RES-1
- V_RES, 480, lines per frame; clear sweep y range 0..V_RES-1
- HIST_W, 4, history bits per pixel
- FIFO_DEPTH, 4, write-back FIFO entries (power of two)
- STABLE_THRESH, 3, minimum popcount of the new history for pixel_stable

Ports:
- clk_50  in  1  system clock
- reset  in  1  synchronous, active-high
- hist_valid  in  1  from color_history data_valid
- hist_data  in  HIST_W  from color_history read_data
- hist_x  in  10  from just_read_x
- hist_y  in  10  from just_read_y
- pixel_hit  in  1  current-frame colour match, aligned with hist_valid
- clear_req  in  1  one-cycle pulse: restart the full-memory clear
- write_grant  in  1  write port granted this cycle
- write_x  out  10  write address x
- write_y  out  10  write address y
- write_data  out  HIST_W  write data
- write_en  out  1  write request
- pixel_stable  out  1  popcount(new history) >= STABLE_THRESH
- stable_valid  out  1  qualifies pixel_stable
- clear_busy  out  1  high while in S_CLEAR
- overflow  out  1  one-cycle pulse when an update is dropped
- drop_count  out  16  saturating count of dropped updates

Behaviour:
- Reset (synchronous, active-high, clk_50):
  - FSM enters S_CLEAR with sweep address (0,0); FIFO is emptied.
  - write_en, pixel_stable, stable_valid, overflow are 0; drop_count is 0; clear_busy is 1 from the first cycle after reset.
  - write_x, write_y, write_data are 0.
- Update stage (registered, both states):
  - new_hist = {hist_data[HIST_W-2:0], pixel_hit}.
  - Cycle after hist_valid=1: stage_valid=1, stable_valid=1, pixel_stable = (popcount(new_hist) >= STABLE_THRESH).
  - stable_valid is 0 otherwise.
- FSM S_CLEAR:
  - write_en=1, write_data=0, write_x/write_y = sweep address.
  - Sweep address advances only on a cycle with write_grant=1: x increments; at x=H_RES-1, x wraps to 0 and y increments.
  - A granted write at (H_RES-1, V_RES-1) moves the FSM to S_RUN on the next cycle; clear_busy then goes to 0.
  - Updates arriving during S_CLEAR are discarded silently: no FIFO push, no overflow, no drop_count change.
- FSM S_RUN:
  - When stage_valid=1, {x, y, new_hist} is pushed into the FIFO.
  - write_en = FIFO not empty; write_x/write_y/write_data = FIFO head.
  - Pop on a cycle where write_en=1 and write_grant=1.
  - Latency: hist_valid in cycle N with an empty FIFO gives write_en=1 with that entry in cycle N+2.
- FIFO full:
  - If full and no pop occurs in the same cycle, a push is dropped.
  - The drop pulses overflow for one cycle and increments drop_count, which saturates at 16'hFFFF.
  - Push and pop in the same cycle while full: both occur and nothing is dropped.
  - Push and pop in the same cycle while empty: the entry passes through the FIFO (visible at N+2 as normal).
- clear_req:
  - In S_RUN: on the next cycle the FIFO is flushed, the sweep address is reset to (0,0), and the FSM enters S_CLEAR.
  - In S_CLEAR: the sweep restarts at (0,0).
  - clear_req coincident with reset: reset wins.
- write_grant held low: outputs hold steady, with no address advance and no pop.
- drop_count is cleared only by reset, not by clear_req.

Optional Feature:
- Macro: HIST_SKIP_SAME_EN.
- Defined: in S_RUN, an update with new_hist == hist_data is not pushed into the FIFO and is never counted as dropped; pixel_stable and stable_valid are still produced. This cuts write-port traffic for static scenes.
- Undefined: every valid update in S_RUN is pushed, including unchanged ones.

Test Plan:
- Clear sweep:
  - Stimulus: release reset; hold write_grant=1.
  - Required: clear_busy=1 and writes of data 0 in raster order from (0,0) to (639,479), 307200 granted writes in total.
  - Required: clear_busy falls the cycle after the last granted write.
- Basic update:
  - Stimulus: in S_RUN, hist_valid=1, hist_data=4'b0101, hist_x=10, hist_y=20, pixel_hit=1, grant high.
  - Required: two cycles later write_en=1, write_x=10, write_y=20, write_data=4'b1011.
  - Required: pixel_stable=1 (popcount 3) with stable_valid=1 one cycle after hist_valid.
- Overflow:
  - Stimulus: write_grant=0; 6 consecutive updates at (30,40) to (90,100).
  - Required: FIFO holds the first 4 updates.
  - Required: overflow pulses twice and drop_count=2.
  - Stimulus: then raise grant. Required: the 4 entries drain in arrival order.
- Clear mid-run:
  - Stimulus: 3 entries queued, grant=0; pulse clear_req.
  - Required: FIFO flushed, clear_busy=1, first write (0,0) with data 0.
  - Required: updates arriving during the clear produce no writes and no change to drop_count.
- Grant stall during clear:
  - Stimulus: toggle write_grant every other cycle.
  - Required: sweep address advances only on granted cycles, with no skipped or repeated addresses.
- HIST_SKIP_SAME_EN:
  - Stimulus: macro defined; hist_data=4'b1111, pixel_hit=1.
  - Required: no write_en and stable_valid=1 with pixel_stable=1.
  - Stimulus: same case with the macro undefined. Required: one write with data 4'b1111.
